// File: rtl/mips_pkg.sv
// Shared MIPS core types and defaults: MEM-stage FSM encoding, datapath widths, zero constants.
// Pure declarations; no timing or flow control of its own.
package mips_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_REG_W          = 5;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_WAIT = 1'b1;

    localparam logic [DEF_DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [DEF_REG_W-1:0]  ZERO_REG  = '0;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: req/we/addr/wdata out from the core, rdata/ready back; ready completes the access.
// The master holds req and the address phase stable until ready is seen.
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_stage_mem_wb.sv
// MEM/WB pipeline register: 1-cycle latency; bubble clears all fields, load captures the inputs.
// No backpressure of its own; the stage controller decides load vs bubble every cycle.
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic              reg_write_d,
    input  logic              mem_to_reg_d,
    input  logic [DATA_W-1:0] read_data_d,
    input  logic [DATA_W-1:0] alu_result_d,
    input  logic [REG_W-1:0]  write_reg_d,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [REG_W-1:0]  write_reg
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            read_data  <= '0;
            alu_result <= '0;
            write_reg  <= '0;
        end else if (load) begin
            reg_write  <= reg_write_d;
            mem_to_reg <= mem_to_reg_d;
            read_data  <= read_data_d;
            alu_result <= alu_result_d;
            write_reg  <= write_reg_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory access, branch resolution and MEM/WB register; 1 cycle + memory wait cycles.
// Holds the upstream pipeline via stall_out while the bus is not ready; a timeout ends a hung access.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int REG_W          = DEF_REG_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              branch_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] read_data2_in,
    input  logic [REG_W-1:0]  write_reg_in,
    input  logic [DATA_W-1:0] branch_target_in,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              flush_out,
    output logic              stall_out,
    mem_stage_if.master       dmem,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic              mem_error
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mem_op;
    logic             done_ok;
    logic             timeout;
    logic [DATA_W-1:0] rd_capture;

    assign mem_op = mem_read_in | mem_write_in;

    // EX/MEM is frozen during WAIT, so the address phase simply follows the inputs.
    assign dmem.req   = mem_op | (state == S_WAIT);
    assign dmem.we    = mem_write_in;
    assign dmem.addr  = alu_result_in;
    assign dmem.wdata = read_data2_in;

    // cnt is 0 in IDLE, so a timeout of 1 fires in the issue cycle itself.
    assign done_ok   = dmem.req & dmem.ready;
    assign timeout   = dmem.req & ~dmem.ready & (cnt == CNT_LAST);
    assign stall_out = dmem.req & ~dmem.ready & ~(cnt == CNT_LAST);

    assign pc_src        = branch_in & zero_in & ~stall_out;
    assign flush_out     = pc_src;
    assign branch_target = branch_target_in;

    assign rd_capture = (done_ok && mem_read_in && !mem_write_in) ? dmem.rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_error <= 1'b0;
        end else begin
            if (stall_out) begin
                state <= S_WAIT;
                cnt   <= cnt + 1'b1;
            end else begin
                state <= S_IDLE;
                cnt   <= '0;
            end
            if (timeout) begin
                mem_error <= 1'b1;
            end
        end
    end

    mem_wb #(
        .DATA_W(DATA_W),
        .REG_W (REG_W)
    ) u_mem_wb (
        .clk         (clk),
        .reset       (reset),
        .load        (~stall_out),
        .bubble      (stall_out),
        .reg_write_d (reg_write_in & ~timeout),
        .mem_to_reg_d(mem_to_reg_in),
        .read_data_d (rd_capture),
        .alu_result_d(alu_result_in),
        .write_reg_d (write_reg_in),
        .reg_write   (wb_reg_write),
        .mem_to_reg  (wb_mem_to_reg),
        .read_data   (wb_read_data),
        .alu_result  (wb_alu_result),
        .write_reg   (wb_write_reg)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a per-instruction behavioural model and a negedge compare process.
module tb_mem_stage;
    import mips_pkg::*;

    localparam int T = 4;

    typedef struct {
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] target;
        logic [31:0] rdata;
        logic [4:0]  wreg;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    logic reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in, zero_in;
    logic [31:0] alu_result_in, read_data2_in, branch_target_in;
    logic [4:0]  write_reg_in;
    logic        pc_src, flush_out, stall_out, mem_error;
    logic [31:0] branch_target;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;

    mem_stage_if #(.DATA_W(32)) dmem_bus ();

    mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_write_in    (reg_write_in),
        .mem_to_reg_in   (mem_to_reg_in),
        .branch_in       (branch_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .zero_in         (zero_in),
        .alu_result_in   (alu_result_in),
        .read_data2_in   (read_data2_in),
        .write_reg_in    (write_reg_in),
        .branch_target_in(branch_target_in),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .flush_out       (flush_out),
        .stall_out       (stall_out),
        .dmem            (dmem_bus),
        .wb_reg_write    (wb_reg_write),
        .wb_mem_to_reg   (wb_mem_to_reg),
        .wb_read_data    (wb_read_data),
        .wb_alu_result   (wb_alu_result),
        .wb_write_reg    (wb_write_reg),
        .mem_error       (mem_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int req_cnt, stall_cnt, pc_cnt;

    instr_t cur;
    logic exp_req, exp_we, exp_stall, exp_pc;
    logic exp_wb_rw, exp_wb_m2r, exp_err;
    logic [31:0] exp_wb_rd, exp_wb_alu;
    logic [4:0]  exp_wb_wreg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", dmem_bus.req, exp_req);
            chk("we", dmem_bus.we, exp_we);
            chk("addr", dmem_bus.addr, cur.alu);
            chk("wdata", dmem_bus.wdata, cur.wd);
            chk("stall", stall_out, exp_stall);
            chk("pc_src", pc_src, exp_pc);
            chk("flush", flush_out, exp_pc);
            chk("btarget", branch_target, cur.target);
            chk("wb_rw", wb_reg_write, exp_wb_rw);
            chk("wb_m2r", wb_mem_to_reg, exp_wb_m2r);
            chk("wb_rd", wb_read_data, exp_wb_rd);
            chk("wb_alu", wb_alu_result, exp_wb_alu);
            chk("wb_wreg", {27'd0, wb_write_reg}, {27'd0, exp_wb_wreg});
            chk("mem_error", mem_error, exp_err);
            if (dmem_bus.req) req_cnt++;
            if (stall_out) stall_cnt++;
            if (pc_src) pc_cnt++;
        end
    end

    function automatic instr_t mk(input logic rw, m2r, br, rd, wr, z,
                                  input logic [31:0] alu, wd, tgt, rdat, input logic [4:0] wreg);
        instr_t i;
        i.reg_write = rw; i.mem_to_reg = m2r; i.branch = br; i.mem_read = rd;
        i.mem_write = wr; i.zero = z; i.alu = alu; i.wd = wd; i.target = tgt;
        i.rdata = rdat; i.wreg = wreg;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        cur = i;
        reg_write_in = i.reg_write; mem_to_reg_in = i.mem_to_reg; branch_in = i.branch;
        mem_read_in = i.mem_read; mem_write_in = i.mem_write; zero_in = i.zero;
        alu_result_in = i.alu; read_data2_in = i.wd; branch_target_in = i.target;
        write_reg_in = i.wreg;
    endtask

    // delay: cycle index (0 = issue cycle) at which ready arrives, -1 = never.
    // rst_k: cycle index in which reset is asserted, -1 = none.
    task automatic run(input instr_t i, input int delay, input int rst_k);
        bit mem, in_time, tmo;
        int n;
        mem     = i.mem_read | i.mem_write;
        in_time = (delay >= 0) && (delay <= T - 1);
        n       = !mem ? 1 : (in_time ? delay + 1 : T);
        tmo     = mem && !in_time;
        req_cnt = 0; stall_cnt = 0; pc_cnt = 0;
        drive(i);
        for (int k = 0; k < n; k++) begin
            dmem_bus.ready = mem && (k == delay);
            dmem_bus.rdata = dmem_bus.ready ? i.rdata : (32'hBAD0_0000 | k);
            exp_req   = mem;
            exp_we    = i.mem_write;
            exp_stall = (k < n - 1);
            exp_pc    = i.branch & i.zero & ~exp_stall;
            reset     = (k == rst_k);
            @(posedge clk);
            if (k == rst_k || exp_stall) begin
                exp_wb_rw = 0; exp_wb_m2r = 0; exp_wb_rd = 0; exp_wb_alu = 0; exp_wb_wreg = 0;
                if (k == rst_k) exp_err = 0;
            end else begin
                exp_wb_rw   = i.reg_write & ~tmo;
                exp_wb_m2r  = i.mem_to_reg;
                exp_wb_rd   = (i.mem_read && !i.mem_write && !tmo) ? i.rdata : 32'h0;
                exp_wb_alu  = i.alu;
                exp_wb_wreg = i.wreg;
                if (tmo) exp_err = 1;
            end
            #1;
            reset = 1'b0;
            dmem_bus.ready = 1'b0;
            if (k == rst_k) begin
                drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(nop);
        dmem_bus.ready = 1'b0; dmem_bus.rdata = '0;
        exp_wb_rw = 0; exp_wb_m2r = 0; exp_wb_rd = 0; exp_wb_alu = 0; exp_wb_wreg = 0; exp_err = 0;
        exp_req = 0; exp_we = 0; exp_stall = 0; exp_pc = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_wb_rw", wb_reg_write, 1'b0);
        chk("rst_wb_alu", wb_alu_result, ZERO_DATA);
        chk("rst_err", mem_error, 1'b0);
        chk_en = 1'b1;
        run(nop, -1, -1);

        run(mk(1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 5'd5), -1, -1);
        chk("alu_rw", wb_reg_write, 1'b1);
        chk("alu_res", wb_alu_result, 32'h10);
        chk("alu_wreg", {27'd0, wb_write_reg}, 32'd5);
        chk("alu_stalls", stall_cnt, 0);

        run(mk(1, 1, 0, 1, 0, 0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 5'd8), 0, -1);
        chk("ld_rdata", wb_read_data, 32'hDEADBEEF);
        chk("ld_reqs", req_cnt, 1);
        chk("ld_stalls", stall_cnt, 0);

        run(mk(0, 0, 0, 0, 1, 0, 32'h200, 32'h55, 32'h0, 32'h0, 5'd0), 3, -1);
        chk("st_reqs", req_cnt, 4);
        chk("st_stalls", stall_cnt, 3);
        chk("st_rw", wb_reg_write, 1'b0);
        chk("st_alu", wb_alu_result, 32'h200);

        run(mk(1, 1, 0, 1, 0, 0, 32'h104, 32'h0, 32'h0, 32'h1234_5678, 5'd9), 0, -1);
        run(mk(1, 0, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 32'h0, 5'd10), -1, -1);
        run(mk(1, 1, 0, 1, 1, 0, 32'h300, 32'hAA, 32'h0, 32'hFFFF_0000, 5'd11), 1, -1);
        chk("ldst_rd", wb_read_data, 32'h0);

        run(mk(0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h400, 32'h0, 5'd0), -1, -1);
        chk("br_taken", pc_cnt, 1);
        run(mk(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h400, 32'h0, 5'd0), -1, -1);
        chk("br_not_taken", pc_cnt, 0);
        run(mk(1, 1, 1, 1, 0, 1, 32'h108, 32'h0, 32'h500, 32'hCAFE_F00D, 5'd12), 2, -1);
        chk("br_mem_pc", pc_cnt, 1);

        run(mk(1, 1, 0, 1, 0, 0, 32'h180, 32'h0, 32'h0, 32'h1111_2222, 5'd13), -1, -1);
        chk("to_reqs", req_cnt, 4);
        chk("to_stalls", stall_cnt, 3);
        chk("to_rw", wb_reg_write, 1'b0);
        chk("to_err", mem_error, 1'b1);
        run(mk(1, 0, 0, 0, 0, 0, 32'h99, 32'h0, 32'h0, 32'h0, 5'd14), -1, -1);
        chk("err_sticky", mem_error, 1'b1);
        run(mk(1, 1, 0, 1, 0, 0, 32'h184, 32'h0, 32'h0, 32'h3333_4444, 5'd15), 5, -1);

        run(mk(1, 1, 0, 1, 0, 0, 32'h1C0, 32'h0, 32'h0, 32'h5555_6666, 5'd16), 10, 2);
        chk("rst_mid_err", mem_error, 1'b0);
        chk("rst_mid_rw", wb_reg_write, 1'b0);
        run(nop, -1, -1);
        run(mk(1, 1, 0, 1, 0, 0, 32'h1C4, 32'h0, 32'h0, 32'h7777_8888, 5'd17), 1, -1);
        chk("post_rst_rd", wb_read_data, 32'h7777_8888);
        chk("post_rst_reqs", req_cnt, 2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
